// File: rtl/div_monitor.sv
// Checks a 50%-duty divided clock: samples it on both clk edges and measures
// period / high time in half-cycles, flagging duty, period and stuck errors.
module div_monitor #(
    parameter int DIV        = 9,
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_in,
    input  logic             enable,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period_meas,
    output logic [CNT_W-1:0] high_meas,
    output logic             err_period,
    output logic             err_duty,
    output logic             err_stuck,
    output logic [7:0]       err_count,
    output logic             lock
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] PER_EXP   = CNT_W'(2 * DIV);
    localparam logic [CNT_W-1:0] HI_EXP    = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] STUCK_LIM = CNT_W'(4 * DIV);
    localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
    localparam logic [GW-1:0]    LOCK_C    = GW'(LOCK_COUNT);

    typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE, LOCKED} state_t;

    state_t           state, state_nx;
    logic             s_p, s_n, prev;
    logic [CNT_W-1:0] per_cnt, hi_cnt, per_nx, hi_nx, close_per, close_hi;
    logic [GW-1:0]    good_cnt, good_nx;
    logic             rise_a, rise_b, close_win, stuck;
    logic             mv_nx, ep_nx, ed_nx, es_nx, lock_nx;
    logic [CNT_W-1:0] pm_nx, hm_nx;
    logic [7:0]       ec_nx, ec_inc;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v,
                                                 input logic [1:0] d);
        logic [CNT_W:0] s;
        s = {1'b0, v} + {{(CNT_W-1){1'b0}}, d};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] absdiff(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Negedge half of the sample pair; consumed at the following posedge.
    always_ff @(negedge clk) begin
        if (!reset) s_n <= 1'b0;
        else        s_n <= div_in;
    end

    always_comb begin
        rise_a    = s_p & ~prev;
        rise_b    = s_n & ~s_p;
        state_nx  = state;
        per_nx    = per_cnt;
        hi_nx     = hi_cnt;
        good_nx   = good_cnt;
        close_win = 1'b0;
        close_per = per_cnt;
        close_hi  = hi_cnt;
        stuck     = 1'b0;
        mv_nx     = 1'b0;
        ep_nx     = 1'b0;
        ed_nx     = 1'b0;
        es_nx     = 1'b0;
        pm_nx     = period_meas;
        hm_nx     = high_meas;
        ec_inc    = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
        ec_nx     = err_count;
        lock_nx   = lock;

        case (state)
            IDLE: begin
                per_nx  = '0;
                hi_nx   = '0;
                good_nx = '0;
                lock_nx = 1'b0;
                if (enable) state_nx = ACQUIRE;
            end
            ACQUIRE: begin
                per_nx = '0;
                hi_nx  = '0;
                if (rise_a) begin
                    per_nx   = CNT_W'(2);
                    hi_nx    = s_n ? CNT_W'(2) : CNT_W'(1);
                    state_nx = MEASURE;
                end else if (rise_b) begin
                    per_nx   = CNT_W'(1);
                    hi_nx    = CNT_W'(1);
                    state_nx = MEASURE;
                end
            end
            default: begin
                // The rising slot belongs to the new window, never the old one.
                if (rise_a) begin
                    close_win = 1'b1;
                    per_nx    = CNT_W'(2);
                    hi_nx     = s_n ? CNT_W'(2) : CNT_W'(1);
                end else if (rise_b) begin
                    close_win = 1'b1;
                    close_per = sat_add(per_cnt, 2'd1);
                    close_hi  = sat_add(hi_cnt, {1'b0, s_p});
                    per_nx    = CNT_W'(1);
                    hi_nx     = CNT_W'(1);
                end else begin
                    per_nx = sat_add(per_cnt, 2'd2);
                    hi_nx  = sat_add(hi_cnt, {1'b0, s_p} + {1'b0, s_n});
                    stuck  = (per_nx >= STUCK_LIM);
                end
            end
        endcase

        if (close_win) begin
            mv_nx = 1'b1;
            pm_nx = close_per;
            hm_nx = close_hi;
            ep_nx = absdiff(close_per, PER_EXP) > TOL_C;
            ed_nx = absdiff(close_hi, HI_EXP) > TOL_C;
            if (ep_nx || ed_nx) begin
                ec_nx    = ec_inc;
                good_nx  = '0;
                lock_nx  = 1'b0;
                state_nx = MEASURE;
            end else begin
                if (good_cnt != LOCK_C) good_nx = good_cnt + GW'(1);
                if (good_nx == LOCK_C) begin
                    lock_nx  = 1'b1;
                    state_nx = LOCKED;
                end
            end
        end

        if (stuck) begin
            es_nx    = 1'b1;
            ec_nx    = ec_inc;
            good_nx  = '0;
            lock_nx  = 1'b0;
            per_nx   = '0;
            hi_nx    = '0;
            state_nx = ACQUIRE;
        end

        // Disable wins over everything; measurement results stay visible.
        if (!enable) begin
            state_nx = IDLE;
            per_nx   = '0;
            hi_nx    = '0;
            good_nx  = '0;
            lock_nx  = 1'b0;
            mv_nx    = 1'b0;
            ep_nx    = 1'b0;
            ed_nx    = 1'b0;
            es_nx    = 1'b0;
            ec_nx    = err_count;
            pm_nx    = period_meas;
            hm_nx    = high_meas;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s_p         <= 1'b0;
            prev        <= 1'b0;
            state       <= IDLE;
            per_cnt     <= '0;
            hi_cnt      <= '0;
            good_cnt    <= '0;
            meas_valid  <= 1'b0;
            period_meas <= '0;
            high_meas   <= '0;
            err_period  <= 1'b0;
            err_duty    <= 1'b0;
            err_stuck   <= 1'b0;
            err_count   <= '0;
            lock        <= 1'b0;
        end else begin
            s_p         <= div_in;
            prev        <= s_n;
            state       <= state_nx;
            per_cnt     <= per_nx;
            hi_cnt      <= hi_nx;
            good_cnt    <= good_nx;
            meas_valid  <= mv_nx;
            period_meas <= pm_nx;
            high_meas   <= hm_nx;
            err_period  <= ep_nx;
            err_duty    <= ed_nx;
            err_stuck   <= es_nx;
            err_count   <= ec_nx;
            lock        <= lock_nx;
        end
    end

endmodule

// File: doc/div_monitor.md
Name: div_monitor

Overview:
- Downstream checker for the 50%-duty clock divider output (default divide-by-9).
- Samples the divided clock on both edges of clk, so measurements are in half-cycle units.
- Measures period and high time of each divided cycle and compares them to the expected values.
- Reports per-period measurements, error pulses, a saturating error count and a lock flag to the clock-control logic.

Parameters:
- DIV, 9, expected divide ratio (odd or even, ≥2); expected period = 2*DIV half-cycles, expected high time = DIV half-cycles.
- TOL, 0, allowed absolute deviation in half-cycles for both period and high-time checks.
- LOCK_COUNT, 4, consecutive good periods required to assert lock.
- CNT_W, 8, width of measurement counters; must hold 4*DIV.

Ports:
- clk  input  1  reference clock, same clock that drives the divider.
- reset  input  1  synchronous, active-low; applies at both posedge and negedge flops.
- div_in  input  1  divided clock under test.
- enable  input  1  1 = monitor runs; 0 = return to IDLE.
- meas_valid  output  1  one-clk pulse when period_meas/high_meas update.
- period_meas  output  CNT_W  last measured period, in half-cycles.
- high_meas  output  CNT_W  high half-cycles within last period.
- err_period  output  1  one-clk pulse: |period_meas − 2*DIV| > TOL.
- err_duty  output  1  one-clk pulse: |high_meas − DIV| > TOL.
- err_stuck  output  1  one-clk pulse: no rising edge within 4*DIV half-cycles.
- err_count  output  8  saturating count of error events (max 255).
- lock  output  1  level; LOCK_COUNT consecutive good periods seen.

Behaviour:
- Reset:
  - When reset=0 at a clk edge, every flop clears: all outputs 0, FSM=IDLE, both sample flops 0.
  - The negedge flop clears at negedge under the same condition.
- Sampling:
  - s_p captures div_in at posedge; s_n captures div_in at negedge.
  - At posedge k+1, the pair (s_p from posedge k, s_n from negedge k+½) is processed as two samples, in that time order.
  - The previous processed sample is kept for edge detection.
- Rising sample: a sample = 1 whose predecessor = 0.
  - period = samples from one rising sample (inclusive) to the next (exclusive).
  - high = count of 1-samples in that window.
- FSM:
  - IDLE: counters held at 0. enable=1 → ACQUIRE.
  - ACQUIRE: waits for the first rising sample, which starts counting → MEASURE.
  - MEASURE: each rising sample closes a window.
    - Outputs register the measurements, meas_valid pulses, and the checks run.
    - good_cnt increments on a good window and clears on error.
    - good_cnt == LOCK_COUNT → LOCKED.
  - LOCKED: same measuring as MEASURE; any error drops lock and clears good_cnt, FSM → MEASURE.
  - Any state except IDLE: enable=0 → IDLE; lock drops the next cycle; measurement outputs are held.
- Rising sample in either slot of a pair:
  - The window closes at that slot.
  - The second slot's sample, if it is the rising one, starts the new window with count 1.
  - Period/high counts of the two windows are split correctly.
- Stuck:
  - The period counter reaching 4*DIV without a rising sample pulses err_stuck and sets FSM → ACQUIRE.
  - It also clears lock and good_cnt and increments err_count once.
  - meas_valid does not pulse.
- Error counting:
  - err_period and err_duty may pulse together; err_count increments by 1 per erroneous window, not per flag.
  - err_count saturates at 255.
- Latency: meas_valid is high for the cycle following posedge k+1, where posedge k or negedge k+½ sampled the closing rise.
- Widths: counters saturate at 2^CNT_W−1; comparisons are unsigned with explicit absolute difference.

Test Plan:
- Nominal: DIV=9 divider free-running, enable=1 → meas_valid every 9 clk; period_meas=18, high_meas=9, no errors.
  - lock rises on the meas_valid of the 4th good window (5th rising edge after enable).
- Duty fault: div_in high 8 / low 10 half-cycles → err_duty pulses each window, err_period=0, err_count increments by 1 per window, lock=0.
- Period fault after lock: insert one period of 20 half-cycles (high 10) → err_period=1, err_duty=1, err_count+1.
  - lock drops the next cycle and re-asserts after 4 more good windows.
- Stuck: hold div_in=0 after lock → err_stuck after 36 half-cycles (18 clk) of no rise; lock=0, FSM back to ACQUIRE, then recovers on normal input.
- Rise in negedge slot: drive div_in with transitions at negedge only → period_meas=18, high_meas=9, identical to the posedge-aligned case.
- Reset/enable mid-operation:
  - reset=0 for one posedge while LOCKED → all outputs 0 the next cycle, including err_count.
  - enable=0 → lock=0 and no meas_valid until re-enabled.
